// File: rtl/hazard_ctrl.sv
// Hazard controller: tracks in-flight destinations after decode and derives
// operand forwarding, load-use stalls and branch flushes.
module hazard_ctrl #(
  parameter int DEPTH    = 3,
  parameter int REG_BITS = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 1,
  parameter int CNT_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [REG_BITS-1:0]         id_rs,
  input  logic [REG_BITS-1:0]         id_rt,
  input  logic                        id_use_rs,
  input  logic                        id_use_rt,
  input  logic [REG_BITS-1:0]         id_rd,
  input  logic                        id_regwrite,
  input  logic                        id_memread,
  input  logic                        br_taken,
  input  logic                        mem_stall,
  output logic                        stall,
  output logic                        flush,
  output logic [$clog2(DEPTH+1)-1:0]  fwd_rs_sel,
  output logic [$clog2(DEPTH+1)-1:0]  fwd_rt_sel,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [CNT_BITS-1:0]         stall_cnt,
  output logic [CNT_BITS-1:0]         flush_cnt
);

  localparam int SEL_BITS = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]    v_q;
  logic [DEPTH-1:0]    rw_q;
  logic [DEPTH-1:0]    mr_q;
  logic [REG_BITS-1:0] rd_q [DEPTH];

  logic [DEPTH-1:0]    rs_hit;
  logic [DEPTH-1:0]    rt_hit;
  logic                load_use;

  // Scan oldest to youngest so the youngest live producer wins the select.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    rs_hit     = '0;
    rt_hit     = '0;
    load_use   = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rs_hit[k] = v_q[k] && rw_q[k] && (rd_q[k] == id_rs) && (id_rs != '0) && id_use_rs;
      rt_hit[k] = v_q[k] && rw_q[k] && (rd_q[k] == id_rt) && (id_rt != '0) && id_use_rt;
      if (rs_hit[k]) fwd_rs_sel = SEL_BITS'(k + 1);
      if (rt_hit[k]) fwd_rt_sel = SEL_BITS'(k + 1);
      if ((k < LOAD_LAT) && mr_q[k] && (rs_hit[k] || rt_hit[k]) && id_valid)
        load_use = 1'b1;
    end
  end

  assign flush       = br_taken & ~mem_stall;
  assign stall       = load_use & ~flush;
  assign entry_valid = v_q;

  // Entries younger than the resolving branch are squashed; the branch itself moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      rw_q      <= '0;
      mr_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
    end else if (!mem_stall) begin
      v_q[0]  <= id_valid & ~stall & ~flush;
      rd_q[0] <= id_rd;
      rw_q[0] <= id_regwrite;
      mr_q[0] <= id_memread;
      for (int k = 1; k < DEPTH; k++) begin
        v_q[k]  <= v_q[k-1] & ~(flush & (k <= BR_STAGE));
        rd_q[k] <= rd_q[k-1];
        rw_q[k] <= rw_q[k-1];
        mr_q[k] <= mr_q[k-1];
      end
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_BITS'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second narrow-counter instance shares the
// stimulus so counter saturation is reachable in a short run.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       br_taken, mem_stall;

  logic        stall, flush;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [2:0]  entry_valid;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_stall, s_flush;
  logic [1:0]  s_fwd_rs_sel, s_fwd_rt_sel;
  logic [2:0]  s_entry_valid;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .mem_stall(mem_stall), .stall(stall), .flush(flush), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .entry_valid(entry_valid), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_BITS(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .mem_stall(mem_stall), .stall(s_stall), .flush(s_flush), .fwd_rs_sel(s_fwd_rs_sel),
    .fwd_rt_sel(s_fwd_rt_sel), .entry_valid(s_entry_valid), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt)
  );

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic br, input logic ms);
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_rd = rd; id_regwrite = rw; id_memread = mr; br_taken = br; mem_stall = ms;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    checkOutput("rst_entry_valid", 32'(entry_valid), 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    checkOutput("rst_flush", 32'(flush), 32'h0);
    checkOutput("rst_fwd_rs", 32'(fwd_rs_sel), 32'h0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("rst_flush_br", 32'(flush), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU producer rd=5 followed by a consumer of rs=5
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    checkOutput("alu_empty_fwd", 32'(fwd_rs_sel), 32'h0);
    tick();
    applyStimulus(1, 5, 1, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_fwd_rs_e0", 32'(fwd_rs_sel), 32'h1);
    checkOutput("alu_rt_unused", 32'(fwd_rt_sel), 32'h0);
    checkOutput("alu_no_stall", 32'(stall), 32'h0);
    tick();
    checkOutput("alu_fwd_rs_e1", 32'(fwd_rs_sel), 32'h2);
    checkOutput("alu_valid_011", 32'(entry_valid), 32'h3);
    applyStimulus(0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("alu_valid_110", 32'(entry_valid), 32'h6);
    checkOutput("alu_fwd_rs_e2", 32'(fwd_rs_sel), 32'h3);
    drain();
    checkOutput("drain_empty", 32'(entry_valid), 32'h0);

    // Two producers of r6: the youngest must win
    applyStimulus(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    tick();
    tick();
    applyStimulus(1, 6, 1, 6, 1, 0, 0, 0, 0, 0);
    checkOutput("prio_fwd_rs", 32'(fwd_rs_sel), 32'h1);
    checkOutput("prio_fwd_rt", 32'(fwd_rt_sel), 32'h1);
    drain();

    // Writes to r0 never forward nor stall
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("r0_fwd_rs", 32'(fwd_rs_sel), 32'h0);
    checkOutput("r0_fwd_rt", 32'(fwd_rt_sel), 32'h0);
    checkOutput("r0_no_stall", 32'(stall), 32'h0);
    drain();

    // Load rd=7 followed by a consumer of rt=7
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    checkOutput("lu_stall", 32'(stall), 32'h1);
    checkOutput("lu_fwd_rt_e0", 32'(fwd_rt_sel), 32'h1);
    tick();
    checkOutput("lu_bubble", 32'(entry_valid), 32'h2);
    checkOutput("lu_stall_end", 32'(stall), 32'h0);
    checkOutput("lu_fwd_rt_e1", 32'(fwd_rt_sel), 32'h2);
    checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'h1);
    drain();

    // Taken branch with a simultaneous load-use hazard
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    tick();
    checkOutput("br_full", 32'(entry_valid), 32'h7);
    applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 1, 0);
    checkOutput("br_flush", 32'(flush), 32'h1);
    checkOutput("br_stall_masked", 32'(stall), 32'h0);
    tick();
    applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    checkOutput("br_valid_100", 32'(entry_valid), 32'h4);
    checkOutput("br_flush_cnt", 32'(flush_cnt), 32'h1);
    checkOutput("br_stall_cnt", 32'(stall_cnt), 32'h1);
    checkOutput("br_after_stall", 32'(stall), 32'h0);
    drain();

    // Freeze with a pending branch and a load-use hazard
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 1, 1);
    checkOutput("frz_flush", 32'(flush), 32'h0);
    checkOutput("frz_stall", 32'(stall), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("frz_hold", 32'(entry_valid), 32'h7);
    end
    checkOutput("frz_stall_cnt", 32'(stall_cnt), 32'h1);
    checkOutput("frz_flush_cnt", 32'(flush_cnt), 32'h1);
    applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 1, 0);
    checkOutput("rel_flush", 32'(flush), 32'h1);
    checkOutput("rel_stall", 32'(stall), 32'h0);
    tick();
    applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    checkOutput("rel_valid_100", 32'(entry_valid), 32'h4);
    checkOutput("rel_flush_cnt", 32'(flush_cnt), 32'h2);
    checkOutput("rel_stall_cnt", 32'(stall_cnt), 32'h1);
    drain();

    // Self-dependent load repeated: one stall every second edge, 20 stalls
    applyStimulus(1, 0, 0, 7, 1, 7, 1, 1, 0, 0);
    repeat (40) tick();
    checkOutput("sat_wide_cnt", 32'(stall_cnt), 32'd21);
    checkOutput("sat_narrow_cnt", 32'(s_stall_cnt), 32'hF);
    tick();
    checkOutput("mid_stall", 32'(stall), 32'h1);

    // Asynchronous reset in the middle of a stall
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_stall", 32'(stall), 32'h0);
    checkOutput("arst_valid", 32'(entry_valid), 32'h0);
    checkOutput("arst_stall_cnt", 32'(stall_cnt), 32'h0);
    checkOutput("arst_flush_cnt", 32'(flush_cnt), 32'h0);
    checkOutput("arst_fwd_rt", 32'(fwd_rt_sel), 32'h0);
    checkOutput("arst_narrow_cnt", 32'(s_stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_stall", 32'(stall), 32'h0);
    tick();
    checkOutput("post_rst_valid", 32'(entry_valid), 32'h1);
    checkOutput("post_rst_cnt", 32'(stall_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
